sequential_divider_n: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse of the team's 4-bit array multiplier.
- Takes a 2N-bit dividend (a multiplier product) and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock.
- Sits behind the DE10-LITE switch/7-segment top level. It also serves as a self-check partner for the multiplier: Quotient*Divisor + Remainder == Dividend.

---
 rtl/sequential_divider_n_if.sv | 24 ++
 rtl/sequential_divider_n.sv | 102 ++++++++++
 tb/tb_sequential_divider_n.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_n_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side issues Start with operands and collects results on Done.
interface sequential_divider_n_if #(
    parameter int N = 4
) ();
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/sequential_divider_n.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock. The dividend shift register doubles as the
// quotient register, since each iteration shifts one dividend bit out of the
// top and one quotient bit in at the bottom.
module sequential_divider_n #(
    parameter int N = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sequential_divider_n_if.slave   bus
);
    localparam int CNT_W = $clog2(2 * N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*N-1:0]   shreg_q;
    logic [N:0]       prem_q;
    logic [N-1:0]     div_q;

    // Iteration datapath: candidate remainder after shifting, trial subtract,
    // and the restored/updated values for the next edge.
    logic [N:0]       shifted_d;
    logic [N+1:0]     trial_d;
    logic             qbit_d;
    logic [N:0]       prem_d;
    logic [2*N-1:0]   shreg_d;

    // One restoring-division step computed from the current working registers.
    always_comb begin
        shifted_d = {prem_q[N-1:0], shreg_q[2*N-1]};
        trial_d   = {1'b0, shifted_d} - {2'b00, div_q};
        // A clear sign bit means the trial subtraction did not borrow.
        qbit_d    = ~trial_d[N+1];
        prem_d    = qbit_d ? trial_d[N:0] : shifted_d;
        shreg_d   = {shreg_q[2*N-2:0], qbit_d};
    end

    // Control FSM with registered outputs; working registers are not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        shreg_q         <= bus.dividend;
                        div_q           <= bus.divisor;
                        prem_q          <= '0;
                        cnt_q           <= '0;
                        bus.div_by_zero <= 1'b0;
                        if (bus.divisor != '0) begin
                            state_q  <= S_RUN;
                            bus.busy <= 1'b1;
                        end else begin
                            // Division by zero skips iteration entirely.
                            state_q         <= S_DONE;
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    shreg_q <= shreg_d;
                    prem_q  <= prem_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(2 * N - 1)) begin
                        // Final iteration: publish results alongside Done.
                        state_q       <= S_DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.quotient  <= shreg_d;
                        bus.remainder <= prem_d[N-1:0];
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_divider_n.sv
// Self-checking bench for sequential_divider_n (N=4): directed cases, reset
// abort, back-to-back Start, multiplier round-trip and random operands,
// all checked against plain integer division.
module tb_sequential_divider_n;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sequential_divider_n_if #(.N(N)) bus ();

    sequential_divider_n #(.N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not hold.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and wait (bounded) for Done. Operands are scrambled
    // right after the accepting edge to show they are not re-sampled.
    // lat = number of edges after the accepting edge at which Done appeared.
    task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                          output int lat, output int busy_cycles, output logic got_done);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        lat          = -1;
        busy_cycles  = 0;
        got_done     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                lat      = i;
                break;
            end
            tick();
        end
    endtask

    // Full check of one division against the arithmetic reference.
    task automatic run_and_check(input string tag, input logic [7:0] a, input logic [3:0] b);
        int   lat;
        int   bc;
        logic gd;
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        exp_q = (b == 0) ? 8'hFF : 8'(a / b);
        exp_r = (b == 0) ? 4'h0  : 4'(a % b);
        do_div(a, b, lat, bc, gd);
        check({tag, "_done_seen"}, 32'(gd), 32'd1);
        check({tag, "_latency"},  32'(lat), (b == 0) ? 32'd0 : 32'd8);
        check({tag, "_busy_cyc"}, 32'(bc),  (b == 0) ? 32'd0 : 32'd8);
        check({tag, "_quot"},     32'(bus.quotient),    32'(exp_q));
        check({tag, "_rem"},      32'(bus.remainder),   32'(exp_r));
        check({tag, "_dbz"},      32'(bus.div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold_quot"},  32'(bus.quotient), 32'(exp_q));
    endtask

    initial begin
        int   lat;
        int   bc;
        logic gd;
        int   ndone;
        int   last_done;
        int   spacing_bad;
        logic [7:0] a;
        logic [3:0] b;

        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_quot", 32'(bus.quotient),    32'd0);
        check("rst_rem",  32'(bus.remainder),   32'd0);
        check("rst_busy", 32'(bus.busy),        32'd0);
        check("rst_done", 32'(bus.done),        32'd0);
        check("rst_dbz",  32'(bus.div_by_zero), 32'd0);

        // Directed cases, including divide by zero and its clearing.
        run_and_check("c8_d", 8'hC8, 4'hD);
        run_and_check("ff_1", 8'hFF, 4'h1);
        run_and_check("07_9", 8'h07, 4'h9);
        run_and_check("e1_f", 8'hE1, 4'hF);
        run_and_check("5a_0", 8'h5A, 4'h0);
        run_and_check("64_7", 8'h64, 4'h7);

        // Reset sampled at E4 aborts the division in flight.
        bus.start    = 1'b1;
        bus.dividend = 8'hC8;
        bus.divisor  = 4'hD;
        tick();                    // E0
        bus.start = 1'b0;
        tick();                    // E1
        tick();                    // E2
        tick();                    // E3
        rst = 1'b1;
        tick();                    // E4 with reset
        rst = 1'b0;
        check("abort_quot", 32'(bus.quotient),    32'd0);
        check("abort_rem",  32'(bus.remainder),   32'd0);
        check("abort_busy", 32'(bus.busy),        32'd0);
        check("abort_done", 32'(bus.done),        32'd0);
        check("abort_dbz",  32'(bus.div_by_zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
            tick();
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_and_check("post_abort", 8'h64, 4'h7);

        // Start held high: one Done every 10 cycles; operand changes while
        // busy must not disturb the running operation.
        bus.start    = 1'b1;
        bus.dividend = 8'h64;
        bus.divisor  = 4'h7;
        ndone        = 0;
        last_done    = -1;
        spacing_bad  = 0;
        for (int i = 0; i < 42; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                check("held_quot", 32'(bus.quotient),  32'h0E);
                check("held_rem",  32'(bus.remainder), 32'h2);
                if (last_done >= 0 && (i - last_done) != 10) spacing_bad++;
                last_done    = i;
                bus.dividend = 8'h64;
                bus.divisor  = 4'h7;
            end else if (bus.busy === 1'b1) begin
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
            end
        end
        bus.start    = 1'b0;
        bus.dividend = 8'h64;
        bus.divisor  = 4'h7;
        check("held_count",   32'(ndone),       32'd4);
        check("held_spacing", 32'(spacing_bad), 32'd0);
        for (int i = 0; i < 12; i++) tick();

        // Multiplier round-trip: (M*Q)/Q == M with zero remainder.
        for (int m = 0; m < 16; m++) begin
            for (int q = 1; q < 16; q++) begin
                do_div(8'(m * q), 4'(q), lat, bc, gd);
                check("rt_done", 32'(gd), 32'd1);
                check("rt_quot", 32'(bus.quotient),  32'(m));
                check("rt_rem",  32'(bus.remainder), 32'd0);
                tick();
            end
        end

        // Random operands: reconstruct the dividend and bound the remainder.
        for (int k = 0; k < 150; k++) begin
            a = 8'($urandom);
            b = 4'($urandom_range(1, 15));
            do_div(a, b, lat, bc, gd);
            check("rnd_done",  32'(gd), 32'd1);
            check("rnd_recon", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
            check("rnd_rlt",   32'(bus.remainder < b), 32'd1);
            check("rnd_quot",  32'(bus.quotient), 32'(a / b));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
